// File: rtl/s3_pack_tx_if.sv
// Bundle of handshake and bus signals for the S3 ternary packer.
// Ports: start, v (2 bits per trit, trit 0 in v[1:0]), out_byte/out_valid/out_ready byte stream,
//        busy, done, err status.
// master = frame source / byte sink side; slave = packer side.
interface s3_pack_tx_if #(
  parameter int N_TRITS = 700
) ();
  logic                   start;
  logic [2*N_TRITS-1:0]   v;
  logic [7:0]             out_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, v, out_ready,
    input  out_byte, out_valid, busy, done, err
  );

  modport slave (
    input  start, v, out_ready,
    output out_byte, out_valid, busy, done, err
  );
endinterface

// File: rtl/s3_pack_tx.sv
// Packs a 2-bit coded ternary polynomial into bytes, 5 trits per byte in base 3 (S3 pack).
// Latency: byte 0 valid one cycle after start accept; then one byte per cycle at full rate.
// Backpressure: out_byte/out_valid hold while out_ready=0; nothing dropped or duplicated.
//
// Ports:
//   clk8  - clock
//   rst   - synchronous, active-high reset; abandons any frame in progress
//   bus   - slave side of s3_pack_tx_if: start/v frame load, out_byte/out_valid/out_ready
//           byte stream, busy (frame in progress), done (1-cycle end pulse), err (sticky illegal code)
module s3_pack_tx #(
  parameter int N_TRITS = 700
) (
  input  logic           clk8,
  input  logic           rst,
  s3_pack_tx_if.slave    bus
);
  localparam int N_BYTES = N_TRITS / 5;
  localparam int CW      = $clog2(N_BYTES);
  localparam int VW      = 2 * N_TRITS;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [7:0]      pack_byte;
  logic            pack_ill;
  logic [1:0]      code;
  logic            last;

  // The current byte always comes from the low 10 bits of the shift register, so the
  // presented byte and its illegal-code flag are combinational and appear the cycle
  // after the register is loaded or shifted. Horner form: t0 + 3*(t1 + 3*(t2 + ...)).
  always_comb begin
    pack_byte = '0;
    pack_ill  = 1'b0;
    code      = '0;
    for (int j = 4; j >= 0; j--) begin
      code      = sr_q[2*j +: 2];
      pack_ill  = pack_ill | (code == 2'b11);
      pack_byte = (pack_byte * 8'd3) + {6'd0, (code == 2'b11) ? 2'b00 : code};
    end
  end

  assign last = (cnt_q == CW'(N_BYTES - 1));

  always_ff @(posedge clk8) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SEND;
          sr_d    = bus.v;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      SEND: begin
        // start is not looked at here, so it is ignored for the whole frame.
        if (bus.out_ready) begin
          // Fold the byte just accepted into the sticky flag so it survives the shift.
          err_d = err_q | pack_ill;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sr_d  = sr_q >> 10;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.out_byte  = pack_byte;
  assign bus.done      = done_q;
  // err reflects the presented byte immediately, plus everything already sent this frame.
  assign bus.err       = err_q | ((state_q == SEND) & pack_ill);

endmodule
